risc16_control_fsm: RTL and testbench
=====================================

# risc16_control_fsm

Multi-cycle control unit for the 16-bit RiSC-style CPU datapath. It sequences fetch, decode, execute, memory and writeback. It drives the ALU's one-hot operation strobes (ADD, NAND, PASS1, EQ) and consumes the ALU's EQ_out for branch resolution. It also owns the memory read/write handshake and every datapath write enable and mux select.

## Interface
- No parameters; all widths are fixed by the 16-bit ISA.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; start or continue executing instructions.
- opcode  in  3  IR[15:13]; valid from DECODE onward.
- eq_out  in  1  ALU equality result, combinational within the same cycle.
- mem_ready  in  1  memory completes the current request at this edge.
- alu_add, alu_nand, alu_pass1, alu_eq  out  1 each  ALU strobes; at most one is high.
- alu_src1_sel  out  1  0 = regA, 1 = {imm10, 6'b0} (LUI).
- alu_src2_sel  out  1  0 = regB, 1 = sign-extended imm7.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  0 = PC+1, 1 = PC+imm7 (branch), 2 = regB (JALR).
- ir_we  out  1  instruction register load.
- mdr_we  out  1  memory data register load.
- aluout_we  out  1  ALU output register load.
- rf_we  out  1  register file write; writes to r0 are discarded by the regfile.
- wb_sel  out  2  0 = ALUOUT, 1 = MDR, 2 = PC.
- mem_rd, mem_wr  out  1 each  memory request.
- mem_addr_sel  out  1  0 = PC, 1 = ALUOUT.
- state_dbg  out  3  current state encoding.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Outputs are a function of the state and the registered opcode only. The exceptions are pc_we in EXEC (which uses eq_out) and the FETCH/MEM write enables (which use mem_ready).
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run = 1.
- FETCH: mem_rd = 1, mem_addr_sel = 0. Hold until mem_ready.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_sel = 0, then go to DECODE.
- DECODE: no strobes; register file read settles. Go to EXEC.
- EXEC, per opcode:
  - ADD (000): alu_add, aluout_we; go to WB.
  - ADDI (001): alu_add, alu_src2_sel = 1, aluout_we; go to WB.
  - NAND (010): alu_nand, aluout_we; go to WB.
  - LUI (011): alu_pass1, alu_src1_sel = 1, aluout_we; go to WB.
  - SW (100) and LW (101): alu_add, alu_src2_sel = 1, aluout_we; go to MEM.
  - BEQ (110): alu_eq. If eq_out = 1, also pc_we = 1, pc_sel = 1. Retire; go to FETCH.
  - JALR (111): rf_we = 1, wb_sel = 2, pc_we = 1, pc_sel = 2. Retire; go to FETCH.
- MEM: mem_addr_sel = 1.
  - LW: mem_rd = 1; on mem_ready, mdr_we = 1 and go to WB.
  - SW: mem_wr = 1; on mem_ready, retire and go to FETCH.
- WB: rf_we = 1, wb_sel = 1 for LW, otherwise 0. Retire; go to FETCH.
- Leaving IDLE: whenever the next state would be FETCH and run = 0, go to IDLE instead. An instruction always completes; run only stops the machine at an instruction boundary.

## Timing
- Reset (rst_n low, at any time, including mid-transaction): state goes to IDLE immediately and all outputs drop to 0 asynchronously. A pending memory request is abandoned.
- Memory handshake:
  - mem_rd/mem_wr and mem_addr_sel are held stable until an edge at which mem_ready = 1.
  - The request deasserts in the following cycle.
  - mem_ready while no request is pending is ignored.
- Cycle counts with zero wait states (mem_ready already high):
  - ADD, ADDI, NAND, LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, JALR: 3 cycles.
  - Each memory wait state adds 1 cycle.
- instr_retired asserts in the same cycle as the final write enable.
- eq_out is sampled combinationally in EXEC; the branch PC write happens at the end of that cycle.

## Structure
- Shared package risc16_ctrl_pkg holds:
  - opcode constants;
  - the state enum (3-bit);
  - pc_sel and wb_sel encodings.
- Natural split:
  - sub-module risc16_ctrl_decode: purely combinational state/opcode to output decoder;
  - top level: state register and next-state logic.

## Test plan
- Reset with run = 1, then ADD r1,r2,r3 with mem_ready tied high -> state sequence FETCH, DECODE, EXEC, WB. alu_add high only in EXEC; rf_we, wb_sel = 0 and instr_retired high in cycle 4.
- LW with mem_ready low for 3 cycles in MEM -> mem_rd held with mem_addr_sel = 1 for 4 cycles; mdr_we pulses once; WB has wb_sel = 1; 8 cycles total.
- BEQ with eq_out = 1, then again with eq_out = 0 -> pc_we = 1 and pc_sel = 1 in EXEC only for the first; alu_eq high in both; each takes 3 cycles.
- JALR -> in EXEC, rf_we = 1, wb_sel = 2, pc_we = 1, pc_sel = 2 in the same cycle; next state is FETCH.
- run dropped during EXEC of SW -> SW completes its MEM handshake, then the FSM goes to IDLE with all outputs 0 and no new fetch.
- rst_n asserted during FETCH with mem_rd high -> mem_rd and all outputs 0 before the next edge; state_dbg reads IDLE.

Source files
------------

// File: rtl/risc16_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// risc16_ctrl_pkg
// Shared definitions for the RiSC-16 multi-cycle control unit:
//   - 3-bit opcode constants (IR[15:13])
//   - controller state enumeration (also exported on state_dbg)
//   - pc_sel / wb_sel mux encodings
//   - ctrl_t: bundle of every datapath strobe the controller drives
// -----------------------------------------------------------------------------
package risc16_ctrl_pkg;

    // Instruction opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    // Controller states; the encoding is visible on state_dbg
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SEL_INC  = 2'd0;  // PC + 1
    localparam logic [1:0] PC_SEL_BR   = 2'd1;  // PC + imm7
    localparam logic [1:0] PC_SEL_JALR = 2'd2;  // regB

    // Register-file write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;  // ALUOUT
    localparam logic [1:0] WB_SEL_MDR  = 2'd1;  // MDR
    localparam logic [1:0] WB_SEL_PC   = 2'd2;  // PC (link address)

    // All controller outputs except state_dbg
    typedef struct packed {
        logic       alu_add;
        logic       alu_nand;
        logic       alu_pass1;
        logic       alu_eq;
        logic       alu_src1_sel;
        logic       alu_src2_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       aluout_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_addr_sel;
        logic       instr_retired;
    } ctrl_t;

endpackage

// File: rtl/risc16_ctrl_decode.sv
// -----------------------------------------------------------------------------
// risc16_ctrl_decode
// Purely combinational decoder from (state, latched opcode) to the datapath
// control bundle. eq_out only affects the branch PC write in EXEC; mem_ready
// only affects the write enables / retire pulse in FETCH and MEM.
// Ports:
//   state      in  state_t  current controller state
//   opcode_r   in  3        opcode latched in DECODE
//   eq_out     in  1        ALU equality result
//   mem_ready  in  1        memory completes the current request
//   ctrl_s     out ctrl_t   decoded control strobes
// -----------------------------------------------------------------------------
module risc16_ctrl_decode
    import risc16_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode_r,
    input  logic       eq_out,
    input  logic       mem_ready,
    output ctrl_t      ctrl_s
);

    // Decode control strobes; anything not set explicitly stays 0
    always_comb begin
        ctrl_s = '0;
        case (state)
            ST_IDLE: begin
                ctrl_s = '0;
            end
            ST_FETCH: begin
                ctrl_s.mem_rd       = 1'b1;
                ctrl_s.mem_addr_sel = 1'b0;
                if (mem_ready) begin
                    ctrl_s.ir_we  = 1'b1;
                    ctrl_s.pc_we  = 1'b1;
                    ctrl_s.pc_sel = PC_SEL_INC;
                end else begin
                    ctrl_s.ir_we  = 1'b0;
                    ctrl_s.pc_we  = 1'b0;
                end
            end
            ST_DECODE: begin
                // Register file read settles; no strobes
                ctrl_s = '0;
            end
            ST_EXEC: begin
                case (opcode_r)
                    OP_ADD: begin
                        ctrl_s.alu_add   = 1'b1;
                        ctrl_s.aluout_we = 1'b1;
                    end
                    OP_ADDI, OP_SW, OP_LW: begin
                        // Register + sign-extended imm7 (also the memory address)
                        ctrl_s.alu_add      = 1'b1;
                        ctrl_s.alu_src2_sel = 1'b1;
                        ctrl_s.aluout_we    = 1'b1;
                    end
                    OP_NAND: begin
                        ctrl_s.alu_nand  = 1'b1;
                        ctrl_s.aluout_we = 1'b1;
                    end
                    OP_LUI: begin
                        ctrl_s.alu_pass1    = 1'b1;
                        ctrl_s.alu_src1_sel = 1'b1;
                        ctrl_s.aluout_we    = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl_s.alu_eq        = 1'b1;
                        ctrl_s.instr_retired = 1'b1;
                        if (eq_out) begin
                            ctrl_s.pc_we  = 1'b1;
                            ctrl_s.pc_sel = PC_SEL_BR;
                        end else begin
                            ctrl_s.pc_we  = 1'b0;
                            ctrl_s.pc_sel = PC_SEL_INC;
                        end
                    end
                    OP_JALR: begin
                        // Link write (PC already points at next instr) and jump together
                        ctrl_s.rf_we         = 1'b1;
                        ctrl_s.wb_sel        = WB_SEL_PC;
                        ctrl_s.pc_we         = 1'b1;
                        ctrl_s.pc_sel        = PC_SEL_JALR;
                        ctrl_s.instr_retired = 1'b1;
                    end
                    default: begin
                        ctrl_s = '0;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl_s.mem_addr_sel = 1'b1;
                if (opcode_r == OP_LW) begin
                    ctrl_s.mem_rd = 1'b1;
                    ctrl_s.mdr_we = mem_ready;
                end else if (opcode_r == OP_SW) begin
                    ctrl_s.mem_wr        = 1'b1;
                    ctrl_s.instr_retired = mem_ready;
                end else begin
                    // Unreachable: only loads/stores enter MEM
                    ctrl_s.mem_addr_sel = 1'b0;
                end
            end
            ST_WB: begin
                ctrl_s.rf_we         = 1'b1;
                ctrl_s.instr_retired = 1'b1;
                if (opcode_r == OP_LW) begin
                    ctrl_s.wb_sel = WB_SEL_MDR;
                end else begin
                    ctrl_s.wb_sel = WB_SEL_ALU;
                end
            end
            default: begin
                ctrl_s = '0;
            end
        endcase
    end

endmodule

// File: rtl/risc16_control_fsm.sv
// -----------------------------------------------------------------------------
// risc16_control_fsm
// Multi-cycle control unit for the RiSC-16 datapath: IDLE -> FETCH -> DECODE
// -> EXEC -> [MEM] -> [WB] -> FETCH. Holds the state register and the opcode
// latched in DECODE; all strobes come from risc16_ctrl_decode. Because the
// strobes are decoded from the asynchronously reset state register, asserting
// rst_n low drops every output immediately.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   run                               continue executing at instr boundaries
//   opcode                            IR[15:13], valid from DECODE onward
//   eq_out                            ALU equality result (branch resolve)
//   mem_ready                         memory completes request at this edge
//   alu_add/nand/pass1/eq             one-hot ALU operation strobes
//   alu_src1_sel, alu_src2_sel        ALU operand selects
//   pc_we, pc_sel                     PC write enable / source
//   ir_we, mdr_we, aluout_we          datapath register loads
//   rf_we, wb_sel                     register file write / source
//   mem_rd, mem_wr, mem_addr_sel      memory request and address source
//   state_dbg                         current state encoding
//   instr_retired                     pulse on last cycle of each instruction
// -----------------------------------------------------------------------------
module risc16_control_fsm
    import risc16_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       eq_out,
    input  logic       mem_ready,
    output logic       alu_add,
    output logic       alu_nand,
    output logic       alu_pass1,
    output logic       alu_eq,
    output logic       alu_src1_sel,
    output logic       alu_src2_sel,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       aluout_we,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mem_addr_sel,
    output logic [2:0] state_dbg,
    output logic       instr_retired
);

    state_t     state_r;
    state_t     state_next_s;
    state_t     boundary_s;
    logic [2:0] opcode_r;
    ctrl_t      ctrl_s;

    // At an instruction boundary, stop in IDLE if run has been dropped
    always_comb begin
        if (run) begin
            boundary_s = ST_FETCH;
        end else begin
            boundary_s = ST_IDLE;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode_r)
                    OP_BEQ, OP_JALR: state_next_s = boundary_s;
                    OP_SW, OP_LW:    state_next_s = ST_MEM;
                    default:         state_next_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_next_s = ST_MEM;
                end else if (opcode_r == OP_LW) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = boundary_s;
                end
            end
            ST_WB: begin
                state_next_s = boundary_s;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; opcode is captured once in DECODE so later states see a stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            opcode_r <= OP_ADD;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_DECODE) begin
                opcode_r <= opcode;
            end
        end
    end

    risc16_ctrl_decode u_decode (
        .state     (state_r),
        .opcode_r  (opcode_r),
        .eq_out    (eq_out),
        .mem_ready (mem_ready),
        .ctrl_s    (ctrl_s)
    );

    assign alu_add       = ctrl_s.alu_add;
    assign alu_nand      = ctrl_s.alu_nand;
    assign alu_pass1     = ctrl_s.alu_pass1;
    assign alu_eq        = ctrl_s.alu_eq;
    assign alu_src1_sel  = ctrl_s.alu_src1_sel;
    assign alu_src2_sel  = ctrl_s.alu_src2_sel;
    assign pc_we         = ctrl_s.pc_we;
    assign pc_sel        = ctrl_s.pc_sel;
    assign ir_we         = ctrl_s.ir_we;
    assign mdr_we        = ctrl_s.mdr_we;
    assign aluout_we     = ctrl_s.aluout_we;
    assign rf_we         = ctrl_s.rf_we;
    assign wb_sel        = ctrl_s.wb_sel;
    assign mem_rd        = ctrl_s.mem_rd;
    assign mem_wr        = ctrl_s.mem_wr;
    assign mem_addr_sel  = ctrl_s.mem_addr_sel;
    assign instr_retired = ctrl_s.instr_retired;
    assign state_dbg     = state_r;

endmodule

// File: tb/tb_risc16_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_risc16_control_fsm
// Directed bench for the RiSC-16 control FSM. Each cycle the state and the
// full strobe bus are compared against hand-built expected values at the
// falling edge; inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_risc16_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [2:0] opcode;
    logic       eq_out;
    logic       mem_ready;
    logic       alu_add, alu_nand, alu_pass1, alu_eq;
    logic       alu_src1_sel, alu_src2_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ir_we, mdr_we, aluout_we, rf_we;
    logic [1:0] wb_sel;
    logic       mem_rd, mem_wr, mem_addr_sel;
    logic [2:0] state_dbg;
    logic       instr_retired;

    int n_vec = 0;
    int n_bad = 0;

    // Expected state encodings
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4,  S_WB  = 3'd5;

    // Opcodes
    localparam logic [2:0] O_ADD = 3'd0, O_ADDI = 3'd1, O_NAND = 3'd2, O_LUI = 3'd3,
                           O_SW  = 3'd4, O_LW   = 3'd5, O_BEQ  = 3'd6, O_JALR = 3'd7;

    // Bit masks into the packed strobe bus below
    localparam logic [18:0] B_ADD    = 19'd1 << 18;
    localparam logic [18:0] B_NAND   = 19'd1 << 17;
    localparam logic [18:0] B_PASS1  = 19'd1 << 16;
    localparam logic [18:0] B_EQ     = 19'd1 << 15;
    localparam logic [18:0] B_SRC1   = 19'd1 << 14;
    localparam logic [18:0] B_SRC2   = 19'd1 << 13;
    localparam logic [18:0] B_PCWE   = 19'd1 << 12;
    localparam logic [18:0] B_PC_BR  = 19'd1 << 10;
    localparam logic [18:0] B_PC_JR  = 19'd2 << 10;
    localparam logic [18:0] B_IRWE   = 19'd1 << 9;
    localparam logic [18:0] B_MDRWE  = 19'd1 << 8;
    localparam logic [18:0] B_ALUWE  = 19'd1 << 7;
    localparam logic [18:0] B_RFWE   = 19'd1 << 6;
    localparam logic [18:0] B_WB_MDR = 19'd1 << 4;
    localparam logic [18:0] B_WB_PC  = 19'd2 << 4;
    localparam logic [18:0] B_RD     = 19'd1 << 3;
    localparam logic [18:0] B_WR     = 19'd1 << 2;
    localparam logic [18:0] B_ASEL   = 19'd1 << 1;
    localparam logic [18:0] B_RET    = 19'd1 << 0;
    localparam logic [18:0] B_NONE   = 19'd0;

    logic [18:0] bus;
    assign bus = {alu_add, alu_nand, alu_pass1, alu_eq, alu_src1_sel, alu_src2_sel,
                  pc_we, pc_sel, ir_we, mdr_we, aluout_we, rf_we, wb_sel,
                  mem_rd, mem_wr, mem_addr_sel, instr_retired};

    always #5 clk = ~clk;

    risc16_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .opcode        (opcode),
        .eq_out        (eq_out),
        .mem_ready     (mem_ready),
        .alu_add       (alu_add),
        .alu_nand      (alu_nand),
        .alu_pass1     (alu_pass1),
        .alu_eq        (alu_eq),
        .alu_src1_sel  (alu_src1_sel),
        .alu_src2_sel  (alu_src2_sel),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .ir_we         (ir_we),
        .mdr_we        (mdr_we),
        .aluout_we     (aluout_we),
        .rf_we         (rf_we),
        .wb_sel        (wb_sel),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr_sel  (mem_addr_sel),
        .state_dbg     (state_dbg),
        .instr_retired (instr_retired)
    );

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    // Check one clock cycle at the falling edge, then step past the next rising edge
    task automatic cyc(input string tag, input logic [2:0] st, input logic [18:0] exp);
        @(negedge clk);
        chk({tag, ".state"}, {16'd0, state_dbg}, {16'd0, st});
        chk({tag, ".out"}, bus, exp);
        @(posedge clk);
        #1;
    endtask

    // Register-to-register instruction: FETCH, DECODE, EXEC, WB
    task automatic alu_instr(input string tag, input logic [2:0] op, input logic [18:0] exec_exp);
        opcode = op;
        cyc({tag, ".fetch"},  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc({tag, ".decode"}, S_DEC,   B_NONE);
        cyc({tag, ".exec"},   S_EXEC,  exec_exp);
        cyc({tag, ".wb"},     S_WB,    B_RFWE | B_RET);
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        eq_out    = 1'b0;
        opcode    = O_ADD;
        #12;
        chk("reset.state", {16'd0, state_dbg}, {16'd0, S_IDLE});
        chk("reset.out", bus, B_NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("idle_start", S_IDLE, B_NONE);

        // ALU-class instructions, zero wait states: 4 cycles each
        alu_instr("add",  O_ADD,  B_ADD | B_ALUWE);
        alu_instr("addi", O_ADDI, B_ADD | B_SRC2 | B_ALUWE);
        alu_instr("nand", O_NAND, B_NAND | B_ALUWE);
        alu_instr("lui",  O_LUI,  B_PASS1 | B_SRC1 | B_ALUWE);

        // LW with 3 memory wait states: 8 cycles
        opcode = O_LW;
        cyc("lw.fetch",  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc("lw.decode", S_DEC,   B_NONE);
        cyc("lw.exec",   S_EXEC,  B_ADD | B_SRC2 | B_ALUWE);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("lw.mem_wait", S_MEM, B_RD | B_ASEL);
        end
        mem_ready = 1'b1;
        cyc("lw.mem_done", S_MEM, B_RD | B_ASEL | B_MDRWE);
        cyc("lw.wb",       S_WB,  B_RFWE | B_WB_MDR | B_RET);

        // BEQ taken, then not taken: 3 cycles each
        opcode = O_BEQ;
        cyc("beq_t.fetch",  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc("beq_t.decode", S_DEC,   B_NONE);
        eq_out = 1'b1;
        cyc("beq_t.exec",   S_EXEC,  B_EQ | B_PCWE | B_PC_BR | B_RET);
        eq_out = 1'b0;
        cyc("beq_n.fetch",  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc("beq_n.decode", S_DEC,   B_NONE);
        cyc("beq_n.exec",   S_EXEC,  B_EQ | B_RET);

        // JALR: link write and jump in the same EXEC cycle, then FETCH
        opcode = O_JALR;
        cyc("jalr.fetch",  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc("jalr.decode", S_DEC,   B_NONE);
        cyc("jalr.exec",   S_EXEC,  B_RFWE | B_WB_PC | B_PCWE | B_PC_JR | B_RET);

        // SW with run dropped in EXEC: store completes, then IDLE
        opcode = O_SW;
        cyc("sw.fetch",  S_FETCH, B_RD | B_IRWE | B_PCWE);
        cyc("sw.decode", S_DEC,   B_NONE);
        run = 1'b0;
        cyc("sw.exec",   S_EXEC,  B_ADD | B_SRC2 | B_ALUWE);
        mem_ready = 1'b0;
        cyc("sw.mem_wait", S_MEM, B_WR | B_ASEL);
        mem_ready = 1'b1;
        cyc("sw.mem_done", S_MEM, B_WR | B_ASEL | B_RET);
        cyc("stop.idle0",  S_IDLE, B_NONE);
        cyc("stop.idle1",  S_IDLE, B_NONE);

        // Restart, stall in FETCH, then reset asynchronously mid-request
        run = 1'b1;
        cyc("restart.idle", S_IDLE, B_NONE);
        mem_ready = 1'b0;
        cyc("fetch.wait",   S_FETCH, B_RD);
        chk("fetch.hold_rd", {18'd0, mem_rd}, 19'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.state", {16'd0, state_dbg}, {16'd0, S_IDLE});
        chk("async_rst.out", bus, B_NONE);
        @(posedge clk);
        #1;
        chk("rst_held.state", {16'd0, state_dbg}, {16'd0, S_IDLE});
        chk("rst_held.out", bus, B_NONE);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
